// File: rtl/blinds_pkg.sv
// Shared types and defaults for the blinds motor driver: FSM state encoding,
// travel target encoding, default parameter values and a sizing helper.
package blinds_pkg;

    typedef enum logic [2:0] {
        ST_STOPPED = 3'd0,
        ST_DEAD    = 3'd1,
        ST_OPENING = 3'd2,
        ST_CLOSING = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    typedef enum logic {
        TGT_CLOSE = 1'b0,
        TGT_OPEN  = 1'b1
    } target_t;

    localparam int DEF_DEADTIME_CYCLES = 4;
    localparam int DEF_TRAVEL_TIMEOUT  = 1000000;
    localparam int DEF_DEBOUNCE_CYCLES = 8;

    // Largest of three counts; used to size the shared cycle counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/blinds_motor_driver_if.sv
// Signal bundle between the blinds controller and its surroundings.
// All signals are plain levels sampled on the rising clock edge; there is no
// valid/ready handshake: commands and limit switches are levels, fault_clear
// is a one-cycle pulse, and every output is valid in every cycle.
// state carries the controller FSM state for observation only.
interface blinds_motor_driver_if;
    import blinds_pkg::*;

    logic   blinds_open;
    logic   limit_open;
    logic   limit_closed;
    logic   fault_clear;
    logic   motor_up;
    logic   motor_down;
    logic   moving;
    logic   at_open;
    logic   at_closed;
    logic   fault;
    state_t state;

    modport master (
        output blinds_open, limit_open, limit_closed, fault_clear,
        input  motor_up, motor_down, moving, at_open, at_closed, fault, state
    );

    modport slave (
        input  blinds_open, limit_open, limit_closed, fault_clear,
        output motor_up, motor_down, moving, at_open, at_closed, fault, state
    );

endinterface

// File: rtl/limit_debounce.sv
// Limit switch conditioner: 2-flop synchronizer followed by a stability
// filter that accepts a new level only after DEBOUNCE_CYCLES stable cycles.
// Only compiled when BLINDS_DEBOUNCE_EN is defined.
`ifdef BLINDS_DEBOUNCE_EN
module limit_debounce #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Bring the asynchronous switch level into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) sync <= 2'b00;
        else     sync <= {sync[0], din};
    end

    // Accept the synchronized level once it has differed from dout long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (sync[1] == dout) begin
            cnt <= '0;
        end else if (cnt >= LAST) begin
            dout <= sync[1];
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule
`endif

// File: rtl/blinds_motor_driver.sv
// Blinds motor controller: drives motor_up/motor_down from a level command,
// stopping at end-stop switches, inserting a motor-off dead time before any
// drive starts or reverses, and faulting on travel timeout or both limits.
// Optional limit debounce: define BLINDS_DEBOUNCE_EN.
module blinds_motor_driver
    import blinds_pkg::*;
#(
    parameter int DEADTIME_CYCLES = DEF_DEADTIME_CYCLES,
    parameter int TRAVEL_TIMEOUT  = DEF_TRAVEL_TIMEOUT,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input logic                   clk,
    input logic                   rst,
    blinds_motor_driver_if.slave  bus
);
    localparam int CNT_MAX = max3(TRAVEL_TIMEOUT, DEADTIME_CYCLES, DEBOUNCE_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DEAD_LAST   = CNT_W'((DEADTIME_CYCLES > 0) ? DEADTIME_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'((TRAVEL_TIMEOUT > 0) ? TRAVEL_TIMEOUT - 1 : 0);

    state_t           state, state_next;
    target_t          target, target_next;
    target_t          cmd;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clear;
    logic             lim_open, lim_closed;

`ifdef BLINDS_DEBOUNCE_EN
    limit_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_open (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.limit_open),
        .dout (lim_open)
    );
    limit_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_closed (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.limit_closed),
        .dout (lim_closed)
    );
`else
    assign lim_open   = bus.limit_open;
    assign lim_closed = bus.limit_closed;
`endif

    assign cmd = bus.blinds_open ? TGT_OPEN : TGT_CLOSE;

    // State and target registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_STOPPED;
            target <= TGT_CLOSE;
        end else begin
            state  <= state_next;
            target <= target_next;
        end
    end

    // Shared dead-time / travel counter: cleared on every state entry, saturating.
    always_ff @(posedge clk) begin
        if (rst || cnt_clear)   cnt <= '0;
        else if (cnt != '1)     cnt <= cnt + 1'b1;
    end

    // Next-state logic; both limits active overrides everything.
    always_comb begin
        state_next  = state;
        target_next = target;
        cnt_clear   = 1'b0;
        if (lim_open && lim_closed) begin
            state_next = ST_FAULT;
            cnt_clear  = (state != ST_FAULT);
        end else begin
            case (state)
                ST_STOPPED: begin
                    if ((cmd == TGT_OPEN && !lim_open) || (cmd == TGT_CLOSE && !lim_closed)) begin
                        state_next  = ST_DEAD;
                        target_next = cmd;
                        cnt_clear   = 1'b1;
                    end
                end
                ST_DEAD: begin
                    if (cmd != target) begin
                        // Command changed mid dead time: restart, or give up if already there.
                        cnt_clear = 1'b1;
                        if ((cmd == TGT_OPEN && lim_open) || (cmd == TGT_CLOSE && lim_closed))
                            state_next = ST_STOPPED;
                        else
                            target_next = cmd;
                    end else if (cnt >= DEAD_LAST) begin
                        state_next = (target == TGT_OPEN) ? ST_OPENING : ST_CLOSING;
                        cnt_clear  = 1'b1;
                    end
                end
                ST_OPENING: begin
                    if (lim_open) begin
                        state_next = ST_STOPPED;
                        cnt_clear  = 1'b1;
                    end else if (cmd == TGT_CLOSE) begin
                        state_next  = ST_DEAD;
                        target_next = TGT_CLOSE;
                        cnt_clear   = 1'b1;
                    end else if (cnt >= TRAVEL_LAST) begin
                        state_next = ST_FAULT;
                        cnt_clear  = 1'b1;
                    end
                end
                ST_CLOSING: begin
                    if (lim_closed) begin
                        state_next = ST_STOPPED;
                        cnt_clear  = 1'b1;
                    end else if (cmd == TGT_OPEN) begin
                        state_next  = ST_DEAD;
                        target_next = TGT_OPEN;
                        cnt_clear   = 1'b1;
                    end else if (cnt >= TRAVEL_LAST) begin
                        state_next = ST_FAULT;
                        cnt_clear  = 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (bus.fault_clear) begin
                        state_next = ST_STOPPED;
                        cnt_clear  = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_STOPPED;
                    cnt_clear  = 1'b1;
                end
            endcase
        end
    end

    // Motor and status decode straight from the registered state.
    always_comb begin
        bus.motor_up   = (state == ST_OPENING);
        bus.motor_down = (state == ST_CLOSING);
        bus.moving     = (state == ST_OPENING) || (state == ST_CLOSING);
        bus.fault      = (state == ST_FAULT);
        bus.state      = state;
    end

    // Registered end-stop status from the (optionally filtered) limits.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.at_open   <= 1'b0;
            bus.at_closed <= 1'b0;
        end else begin
            bus.at_open   <= lim_open;
            bus.at_closed <= lim_closed;
        end
    end

endmodule
